// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte streams,
// optionally holding the grant for a whole packet.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned LOCK_PKT    = 1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     locked,
    output logic                     ack_err
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {ARB, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t            state, state_d;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]   grant_d;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              eligible;
    logic [7:0]        tx_data_d;
    logic              tx_start_d;
    logic              locked_d;
    logic              ack_err_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    int unsigned       idx;

    // Winner selection: locked owner only, else first valid above rr_ptr with wrap.
    always_comb begin
        winner   = grant_id;
        eligible = 1'b0;
        idx      = 0;
        cand     = '0;
        if (locked) begin
            eligible = req_valid[grant_id];
        end else begin
            for (int unsigned k = N_REQ; k >= 1; k--) begin
                idx  = (32'(rr_ptr) + k) % N_REQ;
                cand = ID_W'(idx);
                if (req_valid[cand]) begin
                    winner   = cand;
                    eligible = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        grant_d    = grant_id;
        rr_ptr_d   = rr_ptr;
        locked_d   = locked;
        ack_err_d  = 1'b0;
        cnt_d      = cnt;
        last_d     = last_q;
        req_ready  = '0;
        case (state)
            ARB: begin
                if (rst_n && !tx_busy && eligible) begin
                    req_ready[winner] = 1'b1;
                    tx_data_d  = req_data[{winner, 3'b000} +: 8];
                    grant_d    = winner;
                    rr_ptr_d   = winner;
                    last_d     = req_last[winner];
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 2)) begin
                    // Transmitter never acknowledged: drop the byte and release any lock.
                    ack_err_d = 1'b1;
                    locked_d  = 1'b0;
                    cnt_d     = cnt + 1'b1;
                    state_d   = ARB;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    locked_d = (LOCK_PKT != 0) && !last_q;
                    state_d  = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
            locked   <= 1'b0;
            ack_err  <= 1'b0;
            cnt      <= '0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            grant_id <= grant_d;
            rr_ptr   <= rr_ptr_d;
            locked   <= locked_d;
            ack_err  <= ack_err_d;
            cnt      <= cnt_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, LOCK_PKT=1, ACK_TIMEOUT=16)
// with a small transmitter model that raises busy one cycle after tx_start for 3 cycles.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        locked;
    logic        ack_err;

    int total = 0;
    int bad   = 0;
    int mb_cnt = 0;
    bit model_en = 1'b1;
    bit busy_force = 1'b0;
    int early;
    int rr_id[5]         = '{0, 1, 2, 3, 0};
    logic [7:0] rr_byte[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

    uart_tx_arbiter #(.N_REQ(4), .LOCK_PKT(1), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked), .ack_err(ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model; it is not reset so it finishes a byte independently.
    always @(posedge clk) begin
        if (model_en && tx_start) mb_cnt <= 3;
        else if (mb_cnt != 0)     mb_cnt <= mb_cnt - 1;
    end
    assign tx_busy = (mb_cnt != 0) || busy_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next tx_start; optionally confirm busy rose and fell first.
    task automatic wait_start(input string tag, input bit chk_busy);
        bit rose, fell, got;
        rose = 1'b0; fell = 1'b0; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (tx_start) got = 1'b1;
            else if (tx_busy) rose = 1'b1;
            else if (rose) fell = 1'b1;
        end
        check({tag, "_start"}, 32'(got), 32'd1);
        if (chk_busy) check({tag, "_busyseq"}, 32'(rose & fell), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_start", 32'(tx_start), 32'h0);
        check("rst_data", 32'(tx_data), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_ackerr", 32'(ack_err), 32'h0);
        req_valid = '0;
        @(negedge clk) rst_n = 1'b1;

        // Round robin with every requester valid; each byte is its own packet.
        @(negedge clk);
        req_data = 32'hA3A2A1A0; req_last = 4'hF; req_valid = 4'hF;
        #1 check("rr_first_ready", 32'(req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            wait_start("rr", k > 0);
            check("rr_id", 32'(grant_id), 32'(rr_id[k]));
            check("rr_data", 32'(tx_data), 32'(rr_byte[k]));
        end
        req_valid = '0;
        repeat (8) @(negedge clk);

        // Single requester 2: ready same cycle, start one cycle later.
        req_data[23:16] = 8'h55; req_last = 4'b0100; req_valid = 4'b0100;
        #1 check("single_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        check("single_start", 32'(tx_start), 32'h1);
        check("single_data", 32'(tx_data), 32'h55);
        check("single_grant", 32'(grant_id), 32'h2);
        check("single_ready_drop", 32'(req_ready), 32'h0);
        req_valid = '0;
        repeat (8) @(negedge clk);

        // Locked 3-byte packet from requester 1 while requester 0 waits.
        req_data[15:8] = 8'h11; req_last = 4'b0000; req_valid = 4'b0010;
        #1 check("lk1_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        check("lk1_start", 32'(tx_start), 32'h1);
        check("lk1_grant", 32'(grant_id), 32'h1);
        check("lk1_data", 32'(tx_data), 32'h11);
        check("lk1_locked", 32'(locked), 32'h0);
        req_data[7:0] = 8'h0A; req_last[0] = 1'b1; req_data[15:8] = 8'h12; req_valid = 4'b0011;
        wait_start("lk2", 1'b1);
        check("lk2_grant", 32'(grant_id), 32'h1);
        check("lk2_data", 32'(tx_data), 32'h12);
        check("lk2_locked", 32'(locked), 32'h1);
        req_data[15:8] = 8'h13; req_last[1] = 1'b1;
        wait_start("lk3", 1'b1);
        check("lk3_grant", 32'(grant_id), 32'h1);
        check("lk3_data", 32'(tx_data), 32'h13);
        check("lk3_locked", 32'(locked), 32'h1);
        req_valid = 4'b0001;
        wait_start("lk4", 1'b1);
        check("lk4_grant", 32'(grant_id), 32'h0);
        check("lk4_data", 32'(tx_data), 32'h0A);
        check("lk4_locked", 32'(locked), 32'h0);
        req_valid = '0;
        repeat (8) @(negedge clk);

        // Ack timeout on the second byte of a locked packet.
        req_data[15:8] = 8'h71; req_last = 4'b0000; req_valid = 4'b0010;
        wait_start("to1", 1'b0);
        check("to1_grant", 32'(grant_id), 32'h1);
        check("to1_data", 32'(tx_data), 32'h71);
        req_data[15:8] = 8'h72;
        @(negedge clk) model_en = 1'b0;
        wait_start("to2", 1'b1);
        check("to2_data", 32'(tx_data), 32'h72);
        check("to2_locked", 32'(locked), 32'h1);
        req_valid = 4'b0100; req_data[23:16] = 8'h99; req_last[2] = 1'b1;
        early = 0;
        repeat (15) begin
            @(negedge clk);
            early += int'(ack_err);
        end
        @(negedge clk);
        check("to_early_err", 32'(early), 32'h0);
        check("to_ackerr", 32'(ack_err), 32'h1);
        check("to_locked", 32'(locked), 32'h0);
        check("to_next_ready", 32'(req_ready), 32'h4);
        model_en = 1'b1;
        @(negedge clk);
        check("to_next_start", 32'(tx_start), 32'h1);
        check("to_next_grant", 32'(grant_id), 32'h2);
        check("to_next_data", 32'(tx_data), 32'h99);
        check("to_err_pulse", 32'(ack_err), 32'h0);
        req_valid = '0;
        repeat (8) @(negedge clk);

        // External busy blocks arbitration without error.
        busy_force = 1'b1; req_data[7:0] = 8'h3C; req_last = 4'b0001; req_valid = 4'b0001;
        #1 check("busy_block0", 32'(req_ready), 32'h0);
        early = 0;
        repeat (3) begin
            @(negedge clk);
            early += int'(req_ready != 4'b0000) + int'(ack_err);
        end
        check("busy_block_hold", 32'(early), 32'h0);
        @(negedge clk) busy_force = 1'b0;
        #1 check("busy_release_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("busy_start", 32'(tx_start), 32'h1);
        check("busy_grant", 32'(grant_id), 32'h0);
        check("busy_data", 32'(tx_data), 32'h3C);
        req_valid = '0;
        repeat (8) @(negedge clk);

        // Reset during WAIT_DONE of a locked packet.
        req_data[31:24] = 8'hE1; req_last = 4'b0000; req_valid = 4'b1000;
        wait_start("rs1", 1'b0);
        check("rs1_grant", 32'(grant_id), 32'h3);
        req_data[31:24] = 8'hE2;
        wait_start("rs2", 1'b1);
        check("rs2_locked", 32'(locked), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0; req_data = 32'hD3D2D1D0; req_last = 4'hF; req_valid = 4'hF;
        #1;
        check("mid_rst_start", 32'(tx_start), 32'h0);
        check("mid_rst_data", 32'(tx_data), 32'h0);
        check("mid_rst_grant", 32'(grant_id), 32'h0);
        check("mid_rst_locked", 32'(locked), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        wait_start("rs3", 1'b0);
        check("rs3_grant", 32'(grant_id), 32'h0);
        check("rs3_data", 32'(tx_data), 32'hD0);
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
